// File: rtl/regfile_sb.sv
// Multi-ported register file with a load-busy scoreboard. The top index has no
// storage and always reads the supplied PC value.
module regfile_sb #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16,
   parameter int NRD   = 3,
   localparam int AW    = $clog2(NREGS),
   localparam int PCIDX = NREGS - 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NRD*AW-1:0]    ra,
   output logic [NRD*WIDTH-1:0] rd,
   output logic [NRD-1:0]       rbusy,
   input  logic [WIDTH-1:0]     pc_in,
   input  logic                 we0,
   input  logic [AW-1:0]        wa0,
   input  logic [WIDTH-1:0]     wd0,
   input  logic                 we1,
   input  logic [AW-1:0]        wa1,
   input  logic [WIDTH-1:0]     wd1,
   input  logic                 alloc,
   input  logic [AW-1:0]        alloc_a,
   output logic [NREGS-1:0]     busy_vec,
   output logic                 sb_err
);

   localparam logic [AW-1:0] PC_A = AW'(PCIDX);

   if (NRD < 1 || NRD > 4 || NREGS < 4 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_params
      $error("regfile_sb: NRD must be 1..4 and NREGS a power of two >= 4");
   end

   logic [WIDTH-1:0] regs   [NREGS-1];
   logic [WIDTH-1:0] stored [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic             err_q, err_d;

   // NOTE: the register array is cleared by reset because reads must return 0
   // afterwards; this keeps it a flop array rather than an inferable RAM.
   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < PCIDX; r++) regs[r] <= '0;
      end else begin
         // Port 0 wins when both ports hit the same register.
         for (int r = 0; r < PCIDX; r++) begin
            if (we0 && wa0 == AW'(r))      regs[r] <= wd0;
            else if (we1 && wa1 == AW'(r)) regs[r] <= wd1;
         end
      end
   end

   for (genvar r = 0; r < PCIDX; r++) begin : g_view
      assign stored[r] = regs[r];
   end
   assign stored[PCIDX] = '0;

   // NOTE: every output of an always_comb gets a default first so no path
   // leaves it unassigned and infers a latch.
   always_comb begin
      busy_d = busy_q;
      err_d  = err_q;
      if (we1)   busy_d[wa1]     = 1'b0;
      if (alloc) busy_d[alloc_a] = 1'b1;
      busy_d[PCIDX] = 1'b0;

      if (alloc && busy_q[alloc_a] && !(we1 && wa1 == alloc_a)) err_d = 1'b1;
      if (we1 && !busy_q[wa1])                                 err_d = 1'b1;
      if ((alloc && alloc_a == PC_A) || (we1 && wa1 == PC_A))  err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy_vec = busy_q;
   assign sb_err   = err_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]    a;
      logic [WIDTH-1:0] d;
      logic             b;

      assign a = ra[i*AW +: AW];

      // A load writeback in flight delivers the data now, so it is no longer busy.
      always_comb begin
         d = stored[a];
         b = busy_q[a];
         if (a == PC_A) begin
            d = pc_in;
            b = 1'b0;
         end else if (we0 && wa0 == a) begin
            d = wd0;
         end else if (we1 && wa1 == a) begin
            d = wd1;
            b = 1'b0;
         end
      end

      assign rd[i*WIDTH +: WIDTH] = d;
      assign rbusy[i]             = b;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus queues expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_regfile_sb;

   localparam int WIDTH = 32;
   localparam int NREGS = 16;
   localparam int NRD   = 3;
   localparam int AW    = 4;
   localparam logic [WIDTH-1:0] PC = 32'h0000_1008;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NRD*AW-1:0]    ra;
   logic [NRD*WIDTH-1:0] rd;
   logic [NRD-1:0]       rbusy;
   logic [WIDTH-1:0]     pc_in;
   logic                 we0, we1, alloc;
   logic [AW-1:0]        wa0, wa1, alloc_a;
   logic [WIDTH-1:0]     wd0, wd1;
   logic [NREGS-1:0]     busy_vec;
   logic                 sb_err;

   regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy), .pc_in(pc_in),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .alloc(alloc), .alloc_a(alloc_a), .busy_vec(busy_vec), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   typedef enum logic [1:0] {K_RD, K_RB, K_BV, K_ERR} kind_t;
   typedef struct {
      string            name;
      kind_t            kind;
      int               port;
      logic [WIDTH-1:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always @(negedge clk) begin
      exp_t             e;
      logic [WIDTH-1:0] act;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.kind)
            K_RD:    act = rd[e.port*WIDTH +: WIDTH];
            K_RB:    act = WIDTH'(rbusy[e.port]);
            K_BV:    act = WIDTH'(busy_vec);
            default: act = WIDTH'(sb_err);
         endcase
         vectors++;
         if (act !== e.value) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", e.name, act, e.value);
         end
      end
   end

   task automatic check(input string name, input kind_t k, input int p, input logic [WIDTH-1:0] v);
      exp_t e;
      e.name = name; e.kind = k; e.port = p; e.value = v;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; alloc = 1'b0;
   endtask

   task automatic set_ra(input int p, input logic [AW-1:0] a);
      ra[p*AW +: AW] = a;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; ra = '0; pc_in = PC; idle();
      wa0 = '0; wa1 = '0; alloc_a = '0; wd0 = '0; wd1 = '0;
      step();
      reset = 1'b0;

      // Reset state across all indices.
      check("reset_busy_vec", K_BV, 0, 32'h0);
      check("reset_sb_err", K_ERR, 0, 32'h0);
      for (int a = 0; a < NREGS; a++) begin
         set_ra(a % NRD, AW'(a));
         check($sformatf("reset_rd_idx%0d", a), K_RD, a % NRD, (a == NREGS - 1) ? PC : 32'h0);
         check($sformatf("reset_rbusy_idx%0d", a), K_RB, a % NRD, 32'h0);
         step();
      end

      // ALU write with same-cycle bypass, then from storage.
      we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEAD_BEEF; set_ra(0, 4'd3);
      check("bypass_we0", K_RD, 0, 32'hDEAD_BEEF);
      step();
      idle();
      check("stored_we0", K_RD, 0, 32'hDEAD_BEEF);
      step();

      // Writes to the PC index are dropped.
      we0 = 1'b1; wa0 = 4'd15; wd0 = 32'h1234_5678; set_ra(1, 4'd15);
      check("pc_during_write", K_RD, 1, PC);
      step();
      idle();
      check("pc_after_write", K_RD, 1, PC);
      step();

      // Both ports to address 5: port 0 wins. we1 to a non-busy index flags an error.
      we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h1;
      we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h2; set_ra(2, 4'd5);
      check("dual_write_bypass", K_RD, 2, 32'h1);
      step();
      idle();
      check("dual_write_stored", K_RD, 2, 32'h1);
      check("dual_write_err", K_ERR, 0, 32'h1);
      step();

      // Load flow on index 7.
      do_reset();
      alloc = 1'b1; alloc_a = 4'd7; set_ra(0, 4'd7);
      check("alloc_rbusy_same_cycle", K_RB, 0, 32'h0);
      step();
      idle();
      check("alloc_rbusy_next", K_RB, 0, 32'h1);
      check("alloc_busy_vec", K_BV, 0, 32'h0080);
      step();
      check("alloc_rbusy_hold", K_RB, 0, 32'h1);
      step();
      we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h55;
      check("load_wb_bypass", K_RD, 0, 32'h55);
      check("load_wb_rbusy", K_RB, 0, 32'h0);
      step();
      idle();
      check("load_done_busy_vec", K_BV, 0, 32'h0);
      check("load_done_err", K_ERR, 0, 32'h0);
      check("load_done_stored", K_RD, 0, 32'h55);
      step();

      // Double alloc is sticky error; reset clears; stray we1 sets again.
      alloc = 1'b1; alloc_a = 4'd4;
      step();
      check("double_alloc_pre_err", K_ERR, 0, 32'h0);
      check("double_alloc_busy", K_BV, 0, 32'h0010);
      step();
      idle();
      check("double_alloc_err", K_ERR, 0, 32'h1);
      step();
      check("double_alloc_sticky", K_ERR, 0, 32'h1);
      do_reset();
      check("reset_clears_err", K_ERR, 0, 32'h0);
      check("reset_clears_busy", K_BV, 0, 32'h0);
      we1 = 1'b1; wa1 = 4'd9; wd1 = 32'h9;
      step();
      idle();
      check("stray_we1_err", K_ERR, 0, 32'h1);
      step();

      // Same-cycle alloc and we1 on a busy index: alloc wins, no error.
      do_reset();
      alloc = 1'b1; alloc_a = 4'd2;
      step();
      we1 = 1'b1; wa1 = 4'd2; wd1 = 32'h77; set_ra(0, 4'd2);
      check("alloc_we1_bypass", K_RD, 0, 32'h77);
      check("alloc_we1_rbusy", K_RB, 0, 32'h0);
      step();
      idle();
      check("alloc_we1_busy", K_BV, 0, 32'h0004);
      check("alloc_we1_err", K_ERR, 0, 32'h0);
      step();

      // Reset overrides a concurrent alloc and clears stored data.
      reset = 1'b1; alloc = 1'b1; alloc_a = 4'd6;
      step();
      reset = 1'b0; idle(); set_ra(1, 4'd6);
      check("reset_alloc_busy", K_BV, 0, 32'h0);
      check("reset_clears_data", K_RD, 0, 32'h0);
      check("reset_rbusy6", K_RB, 1, 32'h0);
      step();

      // Alloc to the PC index is an error and never marks it busy.
      alloc = 1'b1; alloc_a = 4'd15;
      step();
      idle();
      check("pc_alloc_busy", K_BV, 0, 32'h0);
      check("pc_alloc_err", K_ERR, 0, 32'h1);
      step();

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d pending, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
